// File: rtl/sha3_pkg.sv
// Constants and FSM state type shared by the SHA3-256 input feeder and its users.
// Rate is 1088 bits: 17 words of 64 bits, 136 bytes.
package sha3_pkg;
    localparam int         RATE_BYTES = 136;
    localparam int         RATE_WORDS = 17;
    localparam logic [7:0] PAD_FIRST  = 8'h06;
    localparam logic [7:0] PAD_LAST   = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;
endpackage

// File: rtl/sha3_block_feeder.sv
// Packs 64-bit message words into SHA3-256 rate blocks, applies 0x06..0x80 padding and hands blocks to the core.
// Block strobe 1 cycle after SEND entry; s_ready stays low from block completion until the core absorbs it.
module sha3_block_feeder
    import sha3_pkg::*;
#(
    parameter int RATE_WORDS = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [63:0]              s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    input  logic [3:0]               s_nbytes,
    output logic                     s_ready,
    output logic [RATE_WORDS*64-1:0] in,
    output logic                     in_valid,
    output logic                     more,
    input  logic                     hash_next,
    input  logic                     out_valid
);
    localparam int BW  = RATE_WORDS * 64;
    localparam int RB  = RATE_WORDS * 8;
    localparam int WCW = $clog2(RATE_WORDS);
    localparam int PW  = $clog2(RB + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WCW-1:0]  r_wcnt;
    logic [BW-1:0]   r_buf;
    logic            r_in_valid;
    logic            r_more;
    logic            r_pad_only;
    logic [PW-1:0]   r_pad_pos;

    logic            w_accept;
    logic            w_absorbed;
    logic [3:0]      w_nbytes;
    logic [63:0]     w_mask;
    logic [63:0]     w_word;
    logic [PW-1:0]   w_pos;

    // Byte-lane mask keeps the leading w_nbytes bytes of the word.
    always_comb begin
        w_nbytes = (!s_last || (s_nbytes > 4'd8)) ? 4'd8 : s_nbytes;
        w_mask   = ~({64{1'b1}} >> {w_nbytes, 3'b000});
        w_word   = s_data & w_mask;
        w_pos    = PW'({r_wcnt, 3'b000}) + PW'(w_nbytes);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        w_accept    = 1'b0;
        w_absorbed  = 1'b0;
        case (r_state)
            ST_FILL: begin
                s_ready  = 1'b1;
                w_accept = s_valid;
                if (s_valid) begin
                    if (s_last) begin
                        w_state_nxt = ST_PAD;
                    end else if (r_wcnt == WCW'(RATE_WORDS - 1)) begin
                        w_state_nxt = ST_SEND;
                    end
                end
            end
            ST_PAD:  w_state_nxt = ST_SEND;
            ST_SEND: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                w_absorbed = r_more ? hash_next : out_valid;
                if (w_absorbed) begin
                    w_state_nxt = r_pad_only ? ST_SEND : ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Slots are only ever written after a clear, so OR-ing a word in is equivalent to overwriting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt     <= '0;
            r_buf      <= '0;
            r_in_valid <= 1'b0;
            r_more     <= 1'b0;
            r_pad_only <= 1'b0;
            r_pad_pos  <= '0;
        end else begin
            r_in_valid <= (r_state == ST_SEND);
            if (w_accept) begin
                r_buf <= r_buf | (BW'(w_word) << (64 * (RATE_WORDS - 1 - int'(r_wcnt))));
                if (s_last) begin
                    r_pad_pos <= w_pos;
                end else if (r_wcnt == WCW'(RATE_WORDS - 1)) begin
                    r_wcnt <= '0;
                    r_more <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + WCW'(1);
                end
            end
            if (r_state == ST_PAD) begin
                r_wcnt <= '0;
                if (int'(r_pad_pos) < RB) begin
                    r_buf  <= r_buf | (BW'(PAD_FIRST) << (8 * (RB - 1 - int'(r_pad_pos))))
                                    | BW'(PAD_LAST);
                    r_more <= 1'b0;
                end else begin
                    r_more     <= 1'b1;
                    r_pad_only <= 1'b1;
                end
            end
            if (w_absorbed) begin
                r_wcnt     <= '0;
                r_more     <= 1'b0;
                r_pad_only <= 1'b0;
                r_buf      <= r_pad_only ? {PAD_FIRST, {(BW - 16){1'b0}}, PAD_LAST} : '0;
            end
        end
    end

    assign in       = r_buf;
    assign in_valid = r_in_valid;
    assign more     = r_more;
endmodule

// File: tb/tb_sha3_block_feeder.sv
// Directed-sequence bench with randomized data, gaps and core response timing, checked against a byte-stream padding model.
module tb_sha3_block_feeder;
    localparam int RW = 17;
    localparam int RB = RW * 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [63:0]       s_data;
    logic              s_valid;
    logic              s_last;
    logic [3:0]        s_nbytes;
    logic              s_ready;
    logic [RW*64-1:0]  blk_in;
    logic              in_valid;
    logic              more;
    logic              hash_next;
    logic              out_valid;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int cyc = 0;
    int xfer_cyc = 0;
    bit core_pend = 0;
    bit prev_iv = 0;
    bit spur_en = 1;

    logic [RW*64-1:0] cap_blk[$];
    bit               cap_more[$];
    int               cap_lat[$];
    byte unsigned     cur_msg[$];
    byte unsigned     exp_stream[$];

    sha3_block_feeder #(.RATE_WORDS(RW)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_nbytes(s_nbytes), .s_ready(s_ready), .in(blk_in), .in_valid(in_valid),
        .more(more), .hash_next(hash_next), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Observes the DUT and plays the role of the SHA3 core, including stray handshake pulses.
    initial begin : mon_core
        int dly;
        bit pm;
        dly = 0;
        pm = 0;
        hash_next = 1'b0;
        out_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            hash_next = 1'b0;
            out_valid = 1'b0;
            if (!rst_n) begin
                core_pend = 0;
                prev_iv = 0;
            end else begin
                if (s_valid && s_ready) xfer_cyc = cyc + 1;
                if ((core_pend || in_valid) && s_ready) viol++;
                if (in_valid && prev_iv) viol++;
                prev_iv = in_valid;
                if (in_valid) begin
                    cap_blk.push_back(blk_in);
                    cap_more.push_back(more);
                    cap_lat.push_back(cyc - xfer_cyc);
                end
                if (core_pend) begin
                    if (dly == 0) begin
                        hash_next = pm;
                        out_valid = !pm;
                        core_pend = 0;
                    end else begin
                        dly--;
                        if (spur_en && $urandom_range(3) == 0) begin
                            hash_next = !pm;
                            out_valid = pm;
                        end
                    end
                end else if (in_valid) begin
                    core_pend = 1;
                    pm = more;
                    dly = $urandom_range(4);
                end else if (spur_en && $urandom_range(7) == 0) begin
                    hash_next = 1'($urandom_range(1));
                    out_valid = !hash_next;
                end
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input bit last, input logic [3:0] nb, input int gap_pct);
        int budget;
        budget = 0;
        while ($urandom_range(99) < gap_pct) begin
            s_valid = 1'b0;
            s_data = {$urandom, $urandom};
            s_last = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        s_data = d;
        s_last = last;
        s_nbytes = nb;
        s_valid = 1'b1;
        forever begin
            if (s_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            budget++;
            if (budget > 2000) break;
        end
        chk("ready_timeout", 64'(budget > 2000), 64'd0);
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = {$urandom, $urandom};
    endtask

    // Reference: message || 0x06 || 0x00.. with 0x80 OR-ed into the final byte of the padded stream.
    task automatic run_msg(input string name, input int gap_pct, input bit over_nb);
        int m, nw, nb, nblk, wait_c, last_idx, idx;
        logic [63:0] w, ew;
        bit last;
        m = cur_msg.size();
        exp_stream = cur_msg;
        exp_stream.push_back(8'h06);
        while (exp_stream.size() % RB != 0) exp_stream.push_back(8'h00);
        exp_stream[exp_stream.size() - 1] = exp_stream[exp_stream.size() - 1] | 8'h80;
        nblk = exp_stream.size() / RB;
        nw = (m == 0) ? 1 : (m + 7) / 8;
        last_idx = (nw - 1) / RW;
        cap_blk.delete();
        cap_more.delete();
        cap_lat.delete();
        viol = 0;
        for (int wi = 0; wi < nw; wi++) begin
            for (int k = 0; k < 8; k++) begin
                idx = 8 * wi + k;
                w[63 - 8 * k -: 8] = (idx < m) ? cur_msg[idx] : 8'($urandom);
            end
            last = (wi == nw - 1);
            nb = last ? (m - 8 * wi) : $urandom_range(15);
            if (last && over_nb && nb == 8) nb = 8 + $urandom_range(1, 7);
            send_word(w, last, 4'(nb), gap_pct);
        end
        wait_c = 0;
        while ((cap_blk.size() < nblk || core_pend) && wait_c < 5000) begin
            @(posedge clk); #1;
            wait_c++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk({name, " nblk"}, 64'(cap_blk.size()), 64'(nblk));
        for (int b = 0; b < nblk && b < cap_blk.size(); b++) begin
            chk($sformatf("%s more%0d", name, b), 64'(cap_more[b]), 64'(b != nblk - 1));
            if (b <= last_idx)
                chk($sformatf("%s lat%0d", name, b), 64'(cap_lat[b]), (b == last_idx) ? 64'd2 : 64'd1);
            for (int wi = 0; wi < RW; wi++) begin
                for (int k = 0; k < 8; k++) ew[63 - 8 * k -: 8] = exp_stream[b * RB + 8 * wi + k];
                chk($sformatf("%s b%0d w%0d", name, b, wi), cap_blk[b][RW*64 - 1 - 64 * wi -: 64], ew);
            end
        end
        chk({name, " protocol"}, 64'(viol), 64'd0);
    endtask

    initial begin : main
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_nbytes = 4'd0;
        s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst in_valid", 64'(in_valid), 64'd0);
        chk("rst more", 64'(more), 64'd0);
        chk("rst in", 64'(|blk_in), 64'd0);
        chk("rst s_ready", 64'(s_ready), 64'd1);

        cur_msg = {};
        run_msg("empty", 0, 0);
        cur_msg = {8'h61, 8'h62, 8'h63};
        run_msg("abc", 0, 0);
        cur_msg = {};
        for (int i = 0; i < 136; i++) cur_msg.push_back(8'($urandom));
        run_msg("len136", 0, 1);
        cur_msg = {};
        for (int i = 0; i < 135; i++) cur_msg.push_back(8'($urandom));
        run_msg("len135", 10, 0);
        cur_msg = {};
        for (int i = 0; i < 200; i++) cur_msg.push_back(8'($urandom));
        run_msg("len200_gaps", 40, 0);
        for (int r = 0; r < 3; r++) begin
            cur_msg = {};
            for (int i = 0, n = $urandom_range(300); i < n; i++) cur_msg.push_back(8'($urandom));
            run_msg($sformatf("rand%0d", r), 25, 1);
        end

        cap_blk.delete();
        for (int i = 0; i < 5; i++) send_word({$urandom, $urandom} | 64'd1, 1'b0, 4'd8, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst in_valid", 64'(in_valid), 64'd0);
        chk("midrst more", 64'(more), 64'd0);
        chk("midrst in", 64'(|blk_in), 64'd0);
        chk("midrst s_ready", 64'(s_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst no block", 64'(cap_blk.size()), 64'd0);
        cur_msg = {8'h61, 8'h62, 8'h63};
        run_msg("abc_after_rst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
